ccr_save_stack: RTL and testbench

Parametrised LIFO that saves condition-code flags on interrupt entry and restores them on RTI. It supports nested interrupts up to DEPTH levels.
- Sits beside the CCR in the execute stage.
- Control unit asserts push on interrupt acceptance and pop on RTI retirement.
- Restored flags are read combinationally from top_data.
- Follows the processor's convention: state written on the negative clock edge, consumers sample on the positive edge.

---
 rtl/ccr_stack_pkg.sv | 10 +
 rtl/ccr_save_stack.sv | 115 +++++++++++
 tb/tb_ccr_save_stack.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ccr_stack_pkg.sv
// Shared constants for the condition-code save stack: flag layout and default nesting depth.
package ccr_stack_pkg;

  localparam int unsigned CCR_W           = 3;
  localparam int unsigned CCR_Z           = 0;
  localparam int unsigned CCR_N           = 1;
  localparam int unsigned CCR_C           = 2;
  localparam int unsigned CCR_STACK_DEPTH = 4;

endpackage

// File: rtl/ccr_save_stack.sv
// LIFO of saved condition codes for nested interrupts; state advances on the falling clock edge.
// Build option CCR_STACK_WRAP_EN: push while full overwrites the oldest entry via a ring base.
module ccr_save_stack
  import ccr_stack_pkg::*;
#(
  parameter int unsigned WIDTH = CCR_W,
  parameter int unsigned DEPTH = CCR_STACK_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] level,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [CNT_W-1:0] wlog;
  logic [PTR_W-1:0] widx;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] top_log;

  assign empty   = (level_q == '0);
  assign full    = (level_q == CNT_W'(DEPTH));
  assign top_log = level_q - CNT_W'(1);

`ifdef CCR_STACK_WRAP_EN
  logic [PTR_W-1:0] base_q, base_d;

  // Logical index 0 is the oldest entry; physical slot is offset by the ring base.
  assign widx    = PTR_W'(wlog) + base_q;
  assign top_idx = PTR_W'(top_log) + base_q;
`else
  assign widx    = PTR_W'(wlog);
  assign top_idx = PTR_W'(top_log);
`endif

  always_comb begin
    level_d = level_q;
    ovf_d   = err_clr ? 1'b0 : ovf_q;
    unf_d   = err_clr ? 1'b0 : unf_q;
    we      = 1'b0;
    wlog    = level_q;
`ifdef CCR_STACK_WRAP_EN
    base_d  = base_q;
`endif
    if (push && pop && !empty) begin
      // RTI immediately re-interrupted: replace top in place.
      we   = 1'b1;
      wlog = top_log;
    end else if (push && !full) begin
      we      = 1'b1;
      wlog    = level_q;
      level_d = level_q + CNT_W'(1);
    end else if (push) begin
      ovf_d = 1'b1;
`ifdef CCR_STACK_WRAP_EN
      we     = 1'b1;
      wlog   = '0;
      base_d = base_q + PTR_W'(1);
`endif
    end else if (pop && !empty) begin
      level_d = level_q - CNT_W'(1);
    end else if (pop) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (we) begin
        mem_q[widx] <= push_data;
      end
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef CCR_STACK_WRAP_EN
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end
`endif

  assign top_data  = empty ? '0 : mem_q[top_idx];
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_ccr_save_stack.sv
// Scoreboard bench for ccr_save_stack: stimulus queues expected state, a monitor drains and compares.
module tb_ccr_save_stack;
  import ccr_stack_pkg::*;

  localparam int unsigned W  = CCR_W;
  localparam int unsigned D  = CCR_STACK_DEPTH;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          pop = 1'b0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  top_data;
  logic [CW-1:0] level;
  logic          empty, full, overflow, underflow;

  ccr_save_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .err_clr   (err_clr),
    .top_data  (top_data),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [W-1:0]  top;
    logic [CW-1:0] lvl;
    logic          emp;
    logic          ful;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t exp_q[$];
  event chk_now;
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compares every queued expectation at the next sample point.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_now);
      #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({top_data, level, empty, full, overflow, underflow} !==
            {e.top, e.lvl, e.emp, e.ful, e.ovf, e.unf}) begin
          failures++;
          $display("FAIL %s: got top=%b lvl=%0d e=%b f=%b ovf=%b unf=%b, want top=%b lvl=%0d e=%b f=%b ovf=%b unf=%b",
                   e.name, top_data, level, empty, full, overflow, underflow,
                   e.top, e.lvl, e.emp, e.ful, e.ovf, e.unf);
        end
      end
    end
  end

  task automatic expect_st(input string name, input int top, input int lvl,
                           input bit ovf, input bit unf);
    exp_t e;
    e.name = name;
    e.top  = W'(top);
    e.lvl  = CW'(lvl);
    e.emp  = (lvl == 0);
    e.ful  = (lvl == D);
    e.ovf  = ovf;
    e.unf  = unf;
    exp_q.push_back(e);
  endtask

  // One strobe cycle: drive after posedge, taken at negedge, released afterwards.
  task automatic op(input bit p, input int d, input bit q, input bit clr);
    @(posedge clk);
    #2;
    push      = p;
    push_data = W'(d);
    pop       = q;
    err_clr   = clr;
    @(negedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: asynchronous reset observed before any clock edge
    #12;
    rst = 1'b0;
    expect_st("reset_async", 0, 0, 0, 0);
    -> chk_now;
    #10;
    @(posedge clk);
    #2;
    rst = 1'b1;

    // 2: basic push/pop
    op(1, 3'b101, 0, 0); expect_st("push_101", 3'b101, 1, 0, 0);
    op(1, 3'b010, 0, 0); expect_st("push_010", 3'b010, 2, 0, 0);
    op(0, 0, 1, 0);      expect_st("pop_to_101", 3'b101, 1, 0, 0);
    op(0, 0, 1, 0);      expect_st("pop_to_empty", 0, 0, 0, 0);

    // 3: fill and overflow
    op(1, 1, 0, 0); expect_st("fill_1", 1, 1, 0, 0);
    op(1, 2, 0, 0); expect_st("fill_2", 2, 2, 0, 0);
    op(1, 3, 0, 0); expect_st("fill_3", 3, 3, 0, 0);
    op(1, 4, 0, 0); expect_st("fill_4", 4, 4, 0, 0);
`ifdef CCR_STACK_WRAP_EN
    op(1, 5, 0, 0); expect_st("ovf_push", 5, 4, 1, 0);
    op(0, 0, 1, 0); expect_st("drain_1", 4, 3, 1, 0);
    op(0, 0, 1, 0); expect_st("drain_2", 3, 2, 1, 0);
    op(0, 0, 1, 0); expect_st("drain_3", 2, 1, 1, 0);
`else
    op(1, 5, 0, 0); expect_st("ovf_push", 4, 4, 1, 0);
    op(0, 0, 1, 0); expect_st("drain_1", 3, 3, 1, 0);
    op(0, 0, 1, 0); expect_st("drain_2", 2, 2, 1, 0);
    op(0, 0, 1, 0); expect_st("drain_3", 1, 1, 1, 0);
`endif
    op(0, 0, 1, 0); expect_st("drain_4", 0, 0, 1, 0);
    op(0, 0, 0, 1); expect_st("ovf_clr", 0, 0, 0, 0);

    // 4: underflow, set wins over clear, then clear
    op(0, 0, 1, 0); expect_st("unf_set", 0, 0, 0, 1);
    op(0, 0, 1, 1); expect_st("unf_set_wins", 0, 0, 0, 1);
    op(0, 0, 0, 1); expect_st("unf_clr", 0, 0, 0, 0);

    // 5: simultaneous push and pop
    op(1, 3'b100, 0, 0); expect_st("sim_pre1", 3'b100, 1, 0, 0);
    op(1, 3'b011, 0, 0); expect_st("sim_pre2", 3'b011, 2, 0, 0);
    op(1, 3'b110, 1, 0); expect_st("sim_replace", 3'b110, 2, 0, 0);
    op(0, 0, 1, 0);      expect_st("sim_below", 3'b100, 1, 0, 0);
    op(0, 0, 1, 0);      expect_st("sim_empty", 0, 0, 0, 0);
    op(1, 3'b001, 1, 0); expect_st("sim_push_empty", 3'b001, 1, 0, 0);
    op(0, 0, 1, 0);      expect_st("sim_done", 0, 0, 0, 0);

    // 6: reset mid-operation with a coincident push
    op(0, 0, 1, 0); expect_st("pre_rst_unf", 0, 0, 0, 1);
    op(1, 1, 0, 0); expect_st("pre_rst_1", 1, 1, 0, 1);
    op(1, 2, 0, 0); expect_st("pre_rst_2", 2, 2, 0, 1);
    op(1, 3, 0, 0); expect_st("pre_rst_3", 3, 3, 0, 1);
    @(posedge clk);
    #2;
    push      = 1'b1;
    push_data = 3'b111;
    rst       = 1'b0;
    expect_st("rst_immediate", 0, 0, 0, 0);
    -> chk_now;
    @(negedge clk);
    #1;
    push = 1'b0;
    expect_st("rst_push_lost", 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    op(1, 3'b110, 0, 0); expect_st("post_rst_push", 3'b110, 1, 0, 0);
    op(0, 0, 1, 0);      expect_st("post_rst_pop", 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
